alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/alu_op_decode.sv | 18 +
 rtl/alu_op_sequencer.sv | 119 +++++++++++
 tb/tb_alu_op_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding, opcode constants and IR field positions for the ALU sequencer
package alu_seq_pkg;
    typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6} state_t;
    typedef enum logic [1:0] {CLS_BIN, CLS_UNARY, CLS_MULDIV, CLS_ILLEGAL} op_class_t;
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    function automatic logic [15:0] reg_sel(input logic [3:0] r);
        reg_sel = 16'h0001 << r;
    endfunction
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: classifies an opcode as binary, unary, two-result (MUL/DIV) or illegal
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [4:0] opcode_i,
    output op_class_t  op_class_o
);
    // pure lookup from opcode to execution class
    always_comb begin
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL: op_class_o = CLS_BIN;
            OP_MUL, OP_DIV:          op_class_o = CLS_MULDIV;
            OP_NEG, OP_NOT:          op_class_o = CLS_UNARY;
            default:                 op_class_o = CLS_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: Moore control FSM fetching and executing one ALU instruction per start request
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           Clear,
    input  logic           start,
    input  logic           mem_ready,
    input  logic [31:0]    IR,
    output logic           busy,
    output logic           done,
    output logic           illegal,
    output logic           PCout,
    output logic           MARin,
    output logic           IncPC,
    output logic           Zin,
    output logic           PCin,
    output logic           Read,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Yin,
    output logic           Zlowout,
    output logic           Zhiout,
    output logic           LOin,
    output logic           HIin,
    output logic [15:0]    Rout,
    output logic [15:0]    Rin,
    output logic [OPW-1:0] IRout
);
    state_t    state_q, state_d;
    op_class_t op_class;
    logic [4:0] ir_op;
    logic [3:0] ir_ra, ir_rb, ir_rc;
    logic       ir_unused;

    assign ir_op     = IR[OP_MSB:OP_LSB];
    assign ir_ra     = IR[RA_MSB:RA_LSB];
    assign ir_rb     = IR[RB_MSB:RB_LSB];
    assign ir_rc     = IR[RC_MSB:RC_LSB];
    assign ir_unused = ^IR[RC_LSB-1:0];

    alu_op_decode u_decode (
        .opcode_i   (ir_op),
        .op_class_o (op_class)
    );

    // state register; Clear drops straight back to IDLE from anywhere
    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next state and strobes, decoded from the current state and IR only
    always_comb begin
        state_d = state_q;
        busy    = state_q != S_IDLE;
        done    = 1'b0;
        illegal = 1'b0;
        PCout   = 1'b0;
        MARin   = 1'b0;
        IncPC   = 1'b0;
        Zin     = 1'b0;
        PCin    = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zlowout = 1'b0;
        Zhiout  = 1'b0;
        LOin    = 1'b0;
        HIin    = 1'b0;
        Rout    = '0;
        Rin     = '0;
        IRout   = '0;
        case (state_q)
            S_IDLE: state_d = start ? S_T0 : S_IDLE;
            S_T0: begin
                {PCout, MARin, IncPC, Zin} = 4'b1111;
                state_d = S_T1;
            end
            S_T1: begin
                {Zlowout, PCin, Read, MDRin} = 4'b1111;
                state_d = mem_ready ? S_T2 : S_T1;
            end
            S_T2: begin
                {MDRout, IRin} = 2'b11;
                state_d = S_T3;
            end
            S_T3: begin
                illegal = op_class == CLS_ILLEGAL;
                Yin     = op_class == CLS_BIN || op_class == CLS_MULDIV;
                Rout    = Yin ? reg_sel(ir_rb) : '0;
                state_d = illegal ? S_IDLE : S_T4;
            end
            S_T4: begin
                IRout   = OPW'(ir_op);
                Zin     = 1'b1;
                Rout    = reg_sel(op_class == CLS_UNARY ? ir_rb : ir_rc);
                state_d = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                LOin    = op_class == CLS_MULDIV;
                done    = !LOin;
                Rin     = LOin ? '0 : reg_sel(ir_ra);
                state_d = LOin ? S_T6 : S_IDLE;
            end
            S_T6: begin
                {Zhiout, HIin, done} = 3'b111;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed-vector bench for the ALU instruction sequencer
module tb_alu_op_sequencer;
    localparam logic [13:0] M_PCOUT  = 14'h2000;
    localparam logic [13:0] M_MARIN  = 14'h1000;
    localparam logic [13:0] M_INCPC  = 14'h0800;
    localparam logic [13:0] M_ZIN    = 14'h0400;
    localparam logic [13:0] M_PCIN   = 14'h0200;
    localparam logic [13:0] M_READ   = 14'h0100;
    localparam logic [13:0] M_MDRIN  = 14'h0080;
    localparam logic [13:0] M_MDROUT = 14'h0040;
    localparam logic [13:0] M_IRIN   = 14'h0020;
    localparam logic [13:0] M_YIN    = 14'h0010;
    localparam logic [13:0] M_ZLO    = 14'h0008;
    localparam logic [13:0] M_ZHI    = 14'h0004;
    localparam logic [13:0] M_LOIN   = 14'h0002;
    localparam logic [13:0] M_HIIN   = 14'h0001;
    localparam logic [2:0]  F_BUSY   = 3'b100;
    localparam logic [2:0]  F_DONE   = 3'b010;
    localparam logic [2:0]  F_ILL    = 3'b001;
    localparam logic [13:0] T0_ST    = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [13:0] T1_ST    = M_ZLO | M_PCIN | M_READ | M_MDRIN;
    localparam logic [13:0] T2_ST    = M_MDROUT | M_IRIN;
    localparam logic [31:0] IR_ROR   = 32'h3891_8000;
    localparam logic [31:0] IR_ADD   = 32'h1891_8000;
    localparam logic [31:0] IR_MUL   = 32'h7822_8000;
    localparam logic [31:0] IR_NOT   = 32'h92B0_0000;
    localparam logic [31:0] IR_BAD   = 32'hF800_0000;

    logic        clk = 1'b0;
    logic        Clear, start, mem_ready;
    logic [31:0] IR;
    logic        busy, done, illegal;
    logic        PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic        Zlowout, Zhiout, LOin, HIin;
    logic [15:0] Rout, Rin;
    logic [4:0]  IRout;
    logic [13:0] strobes;
    int          vectors = 0;
    int          errors = 0;

    assign strobes = {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
                      Zlowout, Zhiout, LOin, HIin};

    alu_op_sequencer #(.OPW(5)) dut (
        .clk(clk), .Clear(Clear), .start(start), .mem_ready(mem_ready), .IR(IR),
        .busy(busy), .done(done), .illegal(illegal),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zlowout(Zlowout), .Zhiout(Zhiout), .LOin(LOin), .HIin(HIin),
        .Rout(Rout), .Rin(Rin), .IRout(IRout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic snap(input string tag, input logic [13:0] st, input logic [15:0] ro,
                        input logic [15:0] ri, input logic [4:0] irv, input logic [2:0] fl);
        chk(tag, 64'({busy, done, illegal, strobes, Rout, Rin, IRout}), 64'({fl, st, ro, ri, irv}));
        chk({tag, " invariants"},
            64'({$onehot0(Rout), $onehot0(Rin),
                 (32'(PCout) + 32'(MDRout) + 32'(Zlowout) + 32'(Zhiout) + 32'(|Rout)) <= 1}),
            64'(3'b111));
    endtask

    task automatic cyc(input string tag, input logic [13:0] st, input logic [15:0] ro,
                       input logic [15:0] ri, input logic [4:0] irv, input logic [2:0] fl);
        @(negedge clk);
        snap(tag, st, ro, ri, irv, fl);
    endtask

    task automatic fetch(input string tag, input bit keep_start);
        cyc({tag, " T0"}, T0_ST, 16'h0, 16'h0, 5'h0, F_BUSY);
        if (!keep_start) start = 1'b0;
        cyc({tag, " T1"}, T1_ST, 16'h0, 16'h0, 5'h0, F_BUSY);
        cyc({tag, " T2"}, T2_ST, 16'h0, 16'h0, 5'h0, F_BUSY);
    endtask

    task automatic run_op(input string tag, input logic [31:0] ir_v, input logic [13:0] t3_st,
                          input logic [15:0] t3_ro, input logic [15:0] t4_ro, input logic [4:0] irv,
                          input logic [15:0] t5_ri, input bit muldiv, input bit keep_start);
        IR = ir_v;
        start = 1'b1;
        fetch(tag, keep_start);
        cyc({tag, " T3"}, t3_st, t3_ro, 16'h0, 5'h0, F_BUSY);
        cyc({tag, " T4"}, M_ZIN, t4_ro, 16'h0, irv, F_BUSY);
        if (muldiv) begin
            cyc({tag, " T5"}, M_ZLO | M_LOIN, 16'h0, 16'h0, 5'h0, F_BUSY);
            cyc({tag, " T6"}, M_ZHI | M_HIIN, 16'h0, 16'h0, 5'h0, F_BUSY | F_DONE);
        end else begin
            cyc({tag, " T5"}, M_ZLO, 16'h0, t5_ri, 5'h0, F_BUSY | F_DONE);
        end
        cyc({tag, " idle"}, 14'h0, 16'h0, 16'h0, 5'h0, 3'b000);
    endtask

    initial begin
        Clear = 1'b0;
        start = 1'b0;
        mem_ready = 1'b1;
        IR = 32'h0;
        cyc("reset a", 14'h0, 16'h0, 16'h0, 5'h0, 3'b000);
        start = 1'b1;
        cyc("reset b", 14'h0, 16'h0, 16'h0, 5'h0, 3'b000);
        start = 1'b0;
        Clear = 1'b1;
        run_op("ror", IR_ROR, M_YIN, 16'h0004, 16'h0008, 5'b00111, 16'h0002, 1'b0, 1'b0);
        run_op("mul", IR_MUL, M_YIN, 16'h0010, 16'h0020, 5'b01111, 16'h0000, 1'b1, 1'b0);
        run_op("not", IR_NOT, 14'h0, 16'h0000, 16'h0040, 5'b10010, 16'h0020, 1'b0, 1'b0);
        IR = IR_ADD;
        mem_ready = 1'b0;
        start = 1'b1;
        cyc("stall T0", T0_ST, 16'h0, 16'h0, 5'h0, F_BUSY);
        start = 1'b0;
        for (int i = 0; i < 4; i++) cyc("stall T1", T1_ST, 16'h0, 16'h0, 5'h0, F_BUSY);
        mem_ready = 1'b1;
        cyc("stall T2", T2_ST, 16'h0, 16'h0, 5'h0, F_BUSY);
        cyc("stall T3", M_YIN, 16'h0004, 16'h0, 5'h0, F_BUSY);
        cyc("stall T4", M_ZIN, 16'h0008, 16'h0, 5'b00011, F_BUSY);
        cyc("stall T5 c9", M_ZLO, 16'h0, 16'h0002, 5'h0, F_BUSY | F_DONE);
        cyc("stall idle", 14'h0, 16'h0, 16'h0, 5'h0, 3'b000);
        IR = IR_BAD;
        start = 1'b1;
        fetch("bad", 1'b0);
        cyc("bad T3", 14'h0, 16'h0, 16'h0, 5'h0, F_BUSY | F_ILL);
        cyc("bad idle", 14'h0, 16'h0, 16'h0, 5'h0, 3'b000);
        IR = IR_ADD;
        start = 1'b1;
        fetch("clr", 1'b0);
        cyc("clr T3", M_YIN, 16'h0004, 16'h0, 5'h0, F_BUSY);
        @(posedge clk);
        #1;
        snap("clr T4 pre", M_ZIN, 16'h0008, 16'h0, 5'b00011, F_BUSY);
        #1;
        Clear = 1'b0;
        #1;
        snap("clr async", 14'h0, 16'h0, 16'h0, 5'h0, 3'b000);
        cyc("clr held", 14'h0, 16'h0, 16'h0, 5'h0, 3'b000);
        Clear = 1'b1;
        cyc("clr idle", 14'h0, 16'h0, 16'h0, 5'h0, 3'b000);
        run_op("add", IR_ADD, M_YIN, 16'h0004, 16'h0008, 5'b00011, 16'h0002, 1'b0, 1'b0);
        run_op("b2b1", IR_ADD, M_YIN, 16'h0004, 16'h0008, 5'b00011, 16'h0002, 1'b0, 1'b1);
        run_op("b2b2", IR_MUL, M_YIN, 16'h0010, 16'h0020, 5'b01111, 16'h0000, 1'b1, 1'b0);
        cyc("final idle", 14'h0, 16'h0, 16'h0, 5'h0, 3'b000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
